spi_adc_dual_rx: RTL and testbench

Dual-channel SPI ADC reader (two AD7476A-class converters on shared CS/SCLK, separate data lines). Sits directly upstream of `spitouart_camp2`: it receives that block's `start` request, runs one 16-bit SPI conversion frame, and returns two 12-bit samples on `data1`/`data2` with a one-cycle `done` strobe. It also flags malformed frames.

---
 rtl/spi_adc_dual_rx_if.sv | 13 +
 rtl/spi_adc_dual_rx.sv | 143 ++++++++++++++
 tb/tb_spi_adc_dual_rx.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_adc_dual_rx_if.sv
// Request/result handshake between the dual-channel ADC reader and its consumer.
// master: issues start and receives samples; slave: the SPI reader.
interface spi_adc_dual_rx_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [11:0] data1;
  logic [11:0] data2;
  logic        frame_err;

  modport master (output start, input busy, done, data1, data2, frame_err);
  modport slave  (input start, output busy, done, data1, data2, frame_err);
endinterface

// File: rtl/spi_adc_dual_rx.sv
// Dual AD7476A-class reader: shared CS/SCLK, two data lines, 16-bit frames
// yielding two 12-bit samples plus a leading-zero violation flag.
module spi_adc_dual_rx #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_adc_dual_rx_if.slave      host,
  output logic                  cs_n,
  output logic                  sclk,
  input  logic                  sdata1,
  input  logic                  sdata2
);
  localparam int DATA_W = 12;
  localparam int DIV_W  = 8;
  localparam int BIT_W  = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, QUIET, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DIV_W-1:0]        div_cnt, div_nxt;
  logic [BIT_W-1:0]        bit_cnt, bit_nxt;
  logic                    phase_hi, phase_nxt;
  logic                    div_end;
  logic [FRAME_BITS-1:0]   sr1, sr2;
  logic                    cs_n_d, sclk_d, busy_d, done_d, shift_en;

  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      phase_hi <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      phase_hi <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    phase_nxt = phase_hi;
    case (state)
      IDLE: begin
        if (host.start) begin
          state_nxt = SETUP;
          div_nxt   = '0;
        end
      end
      SETUP: begin
        if (div_end) begin
          state_nxt = SHIFT;
          div_nxt   = '0;
          bit_nxt   = '0;
          phase_nxt = 1'b0;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        // Each bit period is a low half followed by a high half.
        if (div_end) begin
          div_nxt   = '0;
          phase_nxt = ~phase_hi;
          if (phase_hi) begin
            if (bit_cnt == BIT_LAST) state_nxt = QUIET;
            else                     bit_nxt   = bit_cnt + 1'b1;
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      QUIET: begin
        if (div_end) begin
          state_nxt = DONE;
          div_nxt   = '0;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cs_n_d   = 1'b1;
    sclk_d   = 1'b1;
    busy_d   = (state != IDLE);
    done_d   = 1'b0;
    shift_en = 1'b0;
    case (state)
      SETUP: cs_n_d = 1'b0;
      SHIFT: begin
        cs_n_d   = 1'b0;
        sclk_d   = phase_hi;
        // First cycle of a high half: the registered sclk rises on this edge.
        shift_en = phase_hi && (div_cnt == '0);
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Output register stage: decoded state -> pins, samples and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n           <= 1'b1;
      sclk           <= 1'b1;
      host.busy      <= 1'b0;
      host.done      <= 1'b0;
      host.data1     <= '0;
      host.data2     <= '0;
      host.frame_err <= 1'b0;
    end else begin
      cs_n      <= cs_n_d;
      sclk      <= sclk_d;
      host.busy <= busy_d;
      host.done <= done_d;
      if (done_d) begin
        host.data1     <= sr1[DATA_W-1:0];
        host.data2     <= sr2[DATA_W-1:0];
        host.frame_err <= |{sr1[FRAME_BITS-1:DATA_W], sr2[FRAME_BITS-1:DATA_W]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      sr1 <= {sr1[FRAME_BITS-2:0], sdata1};
      sr2 <= {sr2[FRAME_BITS-2:0], sdata2};
    end
  end
endmodule

// File: tb/tb_spi_adc_dual_rx.sv
// Bench for spi_adc_dual_rx: two instances (CLK_DIV 4 and 1) fed by behavioural ADC models.
module tb_spi_adc_dual_rx;
  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_adc_dual_rx_if ifa ();
  spi_adc_dual_rx_if ifb ();
  logic cs_n_a, sclk_a, cs_n_b, sclk_b;
  logic sd1_a = 1'b0, sd2_a = 1'b0, sd1_b = 1'b0, sd2_b = 1'b0;

  spi_adc_dual_rx #(.CLK_DIV(DIV_A), .FRAME_BITS(16)) dut_a (
    .clk(clk), .rst(rst), .host(ifa), .cs_n(cs_n_a), .sclk(sclk_a),
    .sdata1(sd1_a), .sdata2(sd2_a));
  spi_adc_dual_rx #(.CLK_DIV(DIV_B), .FRAME_BITS(16)) dut_b (
    .clk(clk), .rst(rst), .host(ifb), .cs_n(cs_n_b), .sclk(sclk_b),
    .sdata1(sd1_b), .sdata2(sd2_b));

  int total = 0;
  int bad   = 0;

  // ADC models: word latched when CS falls, MSB presented on the first SCLK fall.
  bit          rand_words = 1'b0;
  logic [15:0] w1_a = '0, w2_a = '0, cur1_a = '0, cur2_a = '0;
  logic [15:0] w1_b = '0, w2_b = '0, cur1_b = '0, cur2_b = '0;
  int idx_a = 0, falls_a = 0, idx_b = 0, falls_b = 0;

  always @(negedge cs_n_a) begin
    if (rand_words) begin
      w1_a = 16'($urandom);
      w2_a = 16'($urandom);
      if ($urandom_range(0, 1) == 0) w1_a[15:12] = 4'h0;
      if ($urandom_range(0, 1) == 0) w2_a[15:12] = 4'h0;
    end
    cur1_a = w1_a; cur2_a = w2_a; idx_a = 15; falls_a = 0;
  end
  always @(negedge sclk_a) begin
    if (cs_n_a == 1'b0) begin
      falls_a++;
      if (idx_a >= 0) begin
        sd1_a = cur1_a[idx_a]; sd2_a = cur2_a[idx_a]; idx_a--;
      end
    end
  end
  always @(negedge cs_n_b) begin
    cur1_b = w1_b; cur2_b = w2_b; idx_b = 15; falls_b = 0;
  end
  always @(negedge sclk_b) begin
    if (cs_n_b == 1'b0) begin
      falls_b++;
      if (idx_b >= 0) begin
        sd1_b = cur1_b[idx_b]; sd2_b = cur2_b[idx_b]; idx_b--;
      end
    end
  end

  // Pulses start on A for one cycle and waits for done; lat counts falling
  // clk edges from the one where start was driven.
  task automatic run_frame_a(input logic [15:0] a, input logic [15:0] b,
                             output int lat, output int low_cyc);
    w1_a = a; w2_a = b;
    lat = -1; low_cyc = 0;
    @(negedge clk);
    ifa.start = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == 1) ifa.start = 1'b0;
      if (cs_n_a == 1'b0) low_cyc++;
      if (ifa.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL frame_timeout got=no_done required=done");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.start = 1'b0; ifb.start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cs_n_a !== 1'b1) begin bad++; $display("FAIL rst_cs_n got=%b required=1", cs_n_a); end
    total++; if (sclk_a !== 1'b1) begin bad++; $display("FAIL rst_sclk got=%b required=1", sclk_a); end
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", ifa.busy); end
    total++; if (ifa.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b required=0", ifa.done); end
    total++; if (ifa.data1 !== 12'h0 || ifa.data2 !== 12'h0) begin
      bad++; $display("FAIL rst_data got=%h/%h required=000/000", ifa.data1, ifa.data2);
    end
    total++; if (ifa.frame_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b required=0", ifa.frame_err); end
    total++; if (cs_n_b !== 1'b1 || sclk_b !== 1'b1) begin
      bad++; $display("FAIL rst_b_pins got=%b%b required=11", cs_n_b, sclk_b);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, low;
    run_frame_a(16'h0A5C, 16'h0FFF, lat, low);
    total++; if (lat != 34 * DIV_A + 2) begin bad++; $display("FAIL basic_latency got=%0d required=%0d", lat, 34 * DIV_A + 2); end
    total++; if (ifa.data1 !== 12'hA5C) begin bad++; $display("FAIL basic_data1 got=%h required=a5c", ifa.data1); end
    total++; if (ifa.data2 !== 12'hFFF) begin bad++; $display("FAIL basic_data2 got=%h required=fff", ifa.data2); end
    total++; if (ifa.frame_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b required=0", ifa.frame_err); end
    total++; if (falls_a != 16) begin bad++; $display("FAIL basic_sclk_falls got=%0d required=16", falls_a); end
    total++; if (low != 33 * DIV_A) begin bad++; $display("FAIL basic_cs_low got=%0d required=%0d", low, 33 * DIV_A); end
    @(negedge clk);
    total++; if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) begin
      bad++; $display("FAIL basic_done_pulse got=done%b busy%b required=done0 busy0", ifa.done, ifa.busy);
    end
  endtask

  task automatic test_frame_err();
    int lat, low;
    run_frame_a(16'h8123, 16'h0456, lat, low);
    total++; if (ifa.data1 !== 12'h123 || ifa.frame_err !== 1'b1) begin
      bad++; $display("FAIL err_ch1 got=%h/%b required=123/1", ifa.data1, ifa.frame_err);
    end
    run_frame_a(16'h0123, 16'h0456, lat, low);
    total++; if (ifa.data1 !== 12'h123 || ifa.data2 !== 12'h456 || ifa.frame_err !== 1'b0) begin
      bad++; $display("FAIL err_clear got=%h/%h/%b required=123/456/0", ifa.data1, ifa.data2, ifa.frame_err);
    end
    run_frame_a(16'h0123, 16'h1000, lat, low);
    total++; if (ifa.data2 !== 12'h000 || ifa.frame_err !== 1'b1) begin
      bad++; $display("FAIL err_ch2 got=%h/%b required=000/1", ifa.data2, ifa.frame_err);
    end
  endtask

  task automatic test_back_to_back();
    int last, ndone, cs_falls, unstable;
    logic [11:0] p1, p2;
    logic pe, prev_cs;
    w1_a = 16'h0321; w2_a = 16'h0654;
    last = -1; ndone = 0; cs_falls = 0; unstable = 0;
    p1 = ifa.data1; p2 = ifa.data2; pe = ifa.frame_err; prev_cs = cs_n_a;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      ifa.start = (k < 400);
      if (prev_cs === 1'b1 && cs_n_a === 1'b0) cs_falls++;
      prev_cs = cs_n_a;
      if (ifa.done === 1'b1) begin
        ndone++;
        if (last >= 0) begin
          total++; if (k - last != 34 * DIV_A + 2) begin
            bad++; $display("FAIL b2b_spacing got=%0d required=%0d", k - last, 34 * DIV_A + 2);
          end
        end
        last = k;
        total++; if (ifa.data1 !== 12'h321 || ifa.data2 !== 12'h654 || ifa.frame_err !== 1'b0) begin
          bad++; $display("FAIL b2b_data got=%h/%h/%b required=321/654/0", ifa.data1, ifa.data2, ifa.frame_err);
        end
      end else if (ifa.data1 !== p1 || ifa.data2 !== p2 || ifa.frame_err !== pe) begin
        unstable++;
      end
      p1 = ifa.data1; p2 = ifa.data2; pe = ifa.frame_err;
    end
    ifa.start = 1'b0;
    total++; if (ndone != 3) begin bad++; $display("FAIL b2b_count got=%0d required=3", ndone); end
    total++; if (cs_falls != 3) begin bad++; $display("FAIL b2b_cs_falls got=%0d required=3", cs_falls); end
    total++; if (unstable != 0) begin bad++; $display("FAIL b2b_stable got=%0d changes required=0", unstable); end
  endtask

  task automatic test_async_reset();
    int seen, dones;
    w1_a = 16'h0777; w2_a = 16'h0888;
    seen = 0; dones = 0;
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cs_n_a === 1'b0 && falls_a == 8) begin
        seen = 1;
        break;
      end
    end
    total++; if (seen == 0) begin bad++; $display("FAIL areset_reach_bit7 got=timeout required=bit7"); end
    #2 rst = 1'b1;
    #1;
    total++; if (cs_n_a !== 1'b1 || sclk_a !== 1'b1 || ifa.busy !== 1'b0) begin
      bad++; $display("FAIL areset_pins got=cs%b sclk%b busy%b required=cs1 sclk1 busy0", cs_n_a, sclk_a, ifa.busy);
    end
    total++; if (ifa.data1 !== 12'h0 || ifa.data2 !== 12'h0) begin
      bad++; $display("FAIL areset_data got=%h/%h required=000/000", ifa.data1, ifa.data2);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ifa.done === 1'b1) dones++;
    end
    total++; if (dones != 0 || cs_n_a !== 1'b1) begin
      bad++; $display("FAIL areset_no_done got=%0d dones cs%b required=0 dones cs1", dones, cs_n_a);
    end
  endtask

  task automatic test_clkdiv1();
    int lat, low, toggles;
    logic prev_sclk;
    w1_b = 16'h0ABC; w2_b = 16'h0555;
    lat = -1; low = 0; toggles = 0;
    @(negedge clk);
    ifb.start = 1'b1;
    prev_sclk = sclk_b;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) ifb.start = 1'b0;
      if (cs_n_b == 1'b0) low++;
      if (sclk_b !== prev_sclk) toggles++;
      prev_sclk = sclk_b;
      if (ifb.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++; if (lat != 34 * DIV_B + 2) begin bad++; $display("FAIL div1_latency got=%0d required=%0d", lat, 34 * DIV_B + 2); end
    total++; if (ifb.data1 !== 12'hABC || ifb.data2 !== 12'h555 || ifb.frame_err !== 1'b0) begin
      bad++; $display("FAIL div1_data got=%h/%h/%b required=abc/555/0", ifb.data1, ifb.data2, ifb.frame_err);
    end
    total++; if (toggles != 32 || falls_b != 16) begin
      bad++; $display("FAIL div1_sclk got=%0d toggles %0d falls required=32 toggles 16 falls", toggles, falls_b);
    end
    total++; if (low != 33 * DIV_B) begin bad++; $display("FAIL div1_cs_low got=%0d required=%0d", low, 33 * DIV_B); end
  endtask

  task automatic test_random();
    bit   open;
    int   cs_k;
    logic prev_cs;
    logic exp_err;
    rand_words = 1'b1;
    open = 1'b0; cs_k = 0; prev_cs = cs_n_a;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (prev_cs === 1'b1 && cs_n_a === 1'b0) begin
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL rnd_cs_without_busy got=busy%b required=busy1", ifa.busy); end
        open = 1'b1; cs_k = k;
      end
      prev_cs = cs_n_a;
      if (ifa.done === 1'b1) begin
        total++;
        if (!open) begin
          bad++; $display("FAIL rnd_spurious_done got=done required=no_done");
        end else begin
          exp_err = (cur1_a[15:12] != 4'h0) || (cur2_a[15:12] != 4'h0);
          if (ifa.data1 !== cur1_a[11:0] || ifa.data2 !== cur2_a[11:0] || ifa.frame_err !== exp_err
              || k - cs_k != 34 * DIV_A || falls_a != 16) begin
            bad++;
            $display("FAIL rnd_frame got=%h/%h/%b lat%0d falls%0d required=%h/%h/%b lat%0d falls16",
                     ifa.data1, ifa.data2, ifa.frame_err, k - cs_k, falls_a,
                     cur1_a[11:0], cur2_a[11:0], exp_err, 34 * DIV_A);
          end
        end
        open = 1'b0;
      end
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        open = 1'b0;
      end
      ifa.start = ($urandom_range(0, 3) == 0);
    end
    ifa.start = 1'b0;
    rst = 1'b0;
    rand_words = 1'b0;
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    test_reset();
    test_basic();
    test_frame_err();
    test_back_to_back();
    test_async_reset();
    test_clkdiv1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
